clave_sequencer: RTL and testbench

Controller for the 13-bit clave measure counter. Generates the counter's `en` tick from the system clock and drives its `go` restart at every measure boundary. Watches the returned count and emits one strobe per clave hit in a 3-2 son clave pattern. Stops after a configured number of measures. Sits between the game-control FSM (start/pause) and the counter, and feeds the hit-judging and display logic.

---
 rtl/clave_pkg.sv | 48 ++++
 rtl/tick_divider.sv | 42 ++++
 rtl/clave_sequencer.sv | 130 +++++++++++++
 tb/tb_clave_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clave_pkg.sv
// -----------------------------------------------------------------------------
// clave_pkg
// Shared definitions for the clave sequencer: FSM state encoding, count width,
// number of clave hits per measure and the hit position table.
//
// Build option: define CLAVE_RUMBA_EN to move the third hit from sixteenth 6
// (son clave, 2475) to sixteenth 7 (rumba clave, 2887). All other positions are
// common to both builds.
// -----------------------------------------------------------------------------
package clave_pkg;

  localparam int COUNT_W  = 13;
  localparam int NUM_HITS = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_WRAP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

`ifdef CLAVE_RUMBA_EN
  localparam logic [COUNT_W-1:0] CLAVE_POS_2 = 13'd2887;
`else
  localparam logic [COUNT_W-1:0] CLAVE_POS_2 = 13'd2475;
`endif

  localparam logic [COUNT_W-1:0] CLAVE_POS [NUM_HITS] = '{
    13'd0, 13'd1237, CLAVE_POS_2, 13'd4125, 13'd4950
  };

  // Position lookup that tolerates an exhausted hit pointer (k == NUM_HITS).
  function automatic logic [COUNT_W-1:0] clave_pos(input logic [2:0] k);
    logic [COUNT_W-1:0] pos;
    pos = '0;
    case (k)
      3'd0:    pos = CLAVE_POS[0];
      3'd1:    pos = CLAVE_POS[1];
      3'd2:    pos = CLAVE_POS[2];
      3'd3:    pos = CLAVE_POS[3];
      3'd4:    pos = CLAVE_POS[4];
      default: pos = '0;
    endcase
    return pos;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Counts 0..TICK_DIV-1 while `run` is high and pulses `tick` combinationally on
// the cycle the count sits at TICK_DIV-1; the count then wraps to 0. When `run`
// is low the count is held, so a paused sequence resumes mid-period.
//
// Ports:
//   clk   in  1  system clock
//   reset in  1  synchronous, active-high
//   clear in  1  forces the count back to 0 (takes priority over run)
//   run   in  1  advance the count
//   tick  out 1  high while run is high and the count is TICK_DIV-1
// Parameter: TICK_DIV (1..65535) clock cycles per tick.
// -----------------------------------------------------------------------------
module tick_divider #(
  parameter int TICK_DIV = 2500
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             at_last;

  assign at_last = (div_cnt == LAST);
  assign tick    = run && at_last;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      div_cnt <= '0;
    end else if (run) begin
      div_cnt <= at_last ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clave_sequencer.sv
// -----------------------------------------------------------------------------
// clave_sequencer
// Drives the 13-bit measure counter (en/go), watches its count and emits one
// strobe per clave hit, stopping after NUM_MEASURES measures.
//
// Ports:
//   clk       in  1   system clock
//   reset     in  1   synchronous, active-high
//   start     in  1   level, acted on in IDLE/DONE only
//   pause     in  1   level, freezes the sequence while high in RUN
//   count_in  in  13  count returned by the measure counter
//   en_out    out 1   counter enable (divider tick while running)
//   go_out    out 1   counter restart (held in IDLE, WRAP, DONE)
//   beat      out 1   one-cycle strobe per clave hit
//   beat_idx  out 3   hit index 0..4, held until the next beat
//   measure   out 4   current measure, 0-based
//   busy      out 1   high in RUN, PAUSE, WRAP
//   done      out 1   high in DONE
// Parameters: TICK_DIV, MAXCOUNT, NUM_MEASURES.
// Build option: CLAVE_RUMBA_EN selects the rumba hit table (see clave_pkg).
// -----------------------------------------------------------------------------
module clave_sequencer
  import clave_pkg::*;
#(
  parameter int TICK_DIV     = 2500,
  parameter int MAXCOUNT     = 6600,
  parameter int NUM_MEASURES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic [COUNT_W-1:0] count_in,
  output logic               en_out,
  output logic               go_out,
  output logic               beat,
  output logic [2:0]         beat_idx,
  output logic [3:0]         measure,
  output logic               busy,
  output logic               done
);

  localparam logic [COUNT_W-1:0] MAX_C  = COUNT_W'(MAXCOUNT);
  localparam logic [3:0]         LAST_M = 4'(NUM_MEASURES - 1);
  localparam logic [2:0]         HITS_C = 3'(NUM_HITS);

  state_t     state, state_nxt;
  logic [2:0] k;
  logic       run, div_clear, at_end, hit_now;

  assign run       = (state == S_RUN);
  // Divider sits at 0 whenever the counter is being restarted, so each
  // measure and each run begins a full divider period.
  assign div_clear = (state == S_IDLE) || (state == S_DONE) || (state == S_WRAP);
  assign at_end    = (count_in == MAX_C);
  // At the terminal count the measure ends; any hit still pending is dropped.
  assign hit_now   = run && !at_end && (k < HITS_C) && (count_in >= clave_pos(k));

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .clear (div_clear),
    .run   (run),
    .tick  (en_out)
  );

  always_comb begin
    state_nxt = state;
    go_out    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        go_out = 1'b1;
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (at_end)     state_nxt = (measure < LAST_M) ? S_WRAP : S_DONE;
        else if (pause) state_nxt = S_PAUSE;
      end
      S_PAUSE: begin
        busy = 1'b1;
        if (!pause) state_nxt = S_RUN;
      end
      S_WRAP: begin
        go_out    = 1'b1;
        busy      = 1'b1;
        state_nxt = S_RUN;
      end
      S_DONE: begin
        go_out = 1'b1;
        done   = 1'b1;
        if (start) state_nxt = S_RUN;
      end
      default: begin
        go_out    = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      k        <= '0;
      measure  <= '0;
      beat     <= 1'b0;
      beat_idx <= '0;
    end else begin
      state <= state_nxt;
      beat  <= hit_now;
      if (hit_now) begin
        beat_idx <= k;
        k        <= k + 3'd1;
      end
      if ((state == S_IDLE || state == S_DONE) && start) begin
        measure <= '0;
        k       <= '0;
      end
      if (state == S_WRAP) begin
        measure <= measure + 4'd1;
        k       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_clave_sequencer.sv
// -----------------------------------------------------------------------------
// tb_clave_sequencer
// Drives clave_sequencer against a behavioural measure counter. Expected hits
// come from the clave rhythm in sixteenths of a measure; randomized pause
// bursts are mixed into the first run.
// -----------------------------------------------------------------------------
module tb_clave_sequencer;

  localparam int TICK_DIV     = 2;
  localparam int MAXCOUNT     = 6600;
  localparam int NUM_MEASURES = 2;
  localparam int MEAS_CYC     = MAXCOUNT * TICK_DIV + 2;
`ifdef CLAVE_RUMBA_EN
  localparam int SIX2 = 7;
`else
  localparam int SIX2 = 6;
`endif

  typedef struct {
    int m;
    int k;
  } hit_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [12:0] count_in = '0;
  logic        en_out, go_out, beat, busy, done;
  logic [2:0]  beat_idx;
  logic [3:0]  measure;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   busy_cycles = 0;
  bit   cnt_busy = 1'b0;
  bit   sb_on = 1'b0;
  logic [12:0] prev_cnt = '0;
  hit_t exp_q[$];

  always #5 clk = ~clk;

  clave_sequencer #(
    .TICK_DIV     (TICK_DIV),
    .MAXCOUNT     (MAXCOUNT),
    .NUM_MEASURES (NUM_MEASURES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .pause    (pause),
    .count_in (count_in),
    .en_out   (en_out),
    .go_out   (go_out),
    .beat     (beat),
    .beat_idx (beat_idx),
    .measure  (measure),
    .busy     (busy),
    .done     (done)
  );

  // Behavioural measure counter: restart on go, count on en, stop at terminal.
  always @(posedge clk) begin
    if (go_out === 1'b1) count_in <= '0;
    else if (en_out === 1'b1 && count_in < 13'(MAXCOUNT)) count_in <= count_in + 13'd1;
  end

  // Hit k lands on a sixteenth of the measure, truncated to a whole count.
  function automatic int ref_pos(input int k);
    int six [5];
    six = '{0, 3, SIX2, 10, 12};
    return (MAXCOUNT * six[k]) / 16;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sb_load(input int nmeas);
    hit_t h;
    for (int m = 0; m < nmeas; m++) begin
      for (int k = 0; k < 5; k++) begin
        h.m = m;
        h.k = k;
        exp_q.push_back(h);
      end
    end
  endtask

  // One clock: outputs are looked at 1 time unit after the rising edge.
  task automatic step();
    hit_t h;
    prev_cnt = count_in;
    @(posedge clk);
    #1;
    if (cnt_busy && busy === 1'b1) busy_cycles++;
    if (sb_on && beat === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("beat_unexpected", exp_q.size(), 1);
      end else begin
        h = exp_q.pop_front();
        check("beat_idx", beat_idx, h.k);
        check("beat_measure", measure, h.m);
        check("beat_pos", prev_cnt, ref_pos(h.k));
      end
    end
  endtask

  task automatic wait_count(input int v, input string tag);
    int n;
    n = 0;
    while (count_in !== 13'(v) && n < 2 * MEAS_CYC) begin
      step();
      n++;
    end
    check(tag, count_in, v);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check(tag, done, 1);
  endtask

  initial begin
    int len, bursts, pause_total, guard, budget;
    logic [12:0] frozen;
    bit got;

    // ---- reset and idle
    repeat (3) step();
    reset = 1'b0;
    repeat (10) step();
    check("idle_go", go_out, 1);
    check("idle_en", en_out, 0);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_beat", beat, 0);
    check("idle_beat_idx", beat_idx, 0);
    check("idle_measure", measure, 0);
    check("idle_count", count_in, 0);

    // ---- full run with random pause bursts
    sb_on = 1'b1;
    sb_load(NUM_MEASURES);
    bursts = 0;
    pause_total = 0;
    guard = 0;
    budget = NUM_MEASURES * MEAS_CYC + 2000;
    cnt_busy = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_go", go_out, 0);
    while (done !== 1'b1 && guard < budget) begin
      if (bursts < 6 && busy === 1'b1 && count_in >= 13'd100 && count_in <= 13'd6000 &&
          $urandom_range(0, 999) < 2) begin
        len = $urandom_range(2, 60);
        pause = 1'b1;
        step();
        guard++;
        check("pause_en_first", en_out, 0);
        frozen = count_in;
        for (int i = 1; i < len; i++) begin
          step();
          guard++;
          check("pause_en", en_out, 0);
          check("pause_busy", busy, 1);
        end
        check("pause_freeze", count_in, frozen);
        pause = 1'b0;
        pause_total += len;
        bursts++;
      end else begin
        step();
        guard++;
      end
    end
    cnt_busy = 1'b0;
    check("run1_done", done, 1);
    check("run1_busy_cycles", busy_cycles, NUM_MEASURES * MEAS_CYC - 1 + pause_total);
    check("run1_hits_left", exp_q.size(), 0);
    check("run1_measure", measure, NUM_MEASURES - 1);
    check("run1_beat_idx", beat_idx, 4);
    check("done_go", go_out, 1);
    check("done_en", en_out, 0);
    check("done_busy", busy, 0);

    // ---- directed pause at count 1000, then pause raised at the terminal count
    sb_load(NUM_MEASURES);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_measure", measure, 0);
    wait_count(1000, "reach_1000");
    pause = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      check("hold_count", count_in, 1000);
      check("hold_en", en_out, 0);
      check("hold_beat", beat, 0);
    end
    pause = 1'b0;
    step();
    check("resume_tick", en_out, 1);
    check("resume_count", count_in, 1000);
    step();
    check("resume_incr", count_in, 1001);
    wait_count(MAXCOUNT, "reach_max");
    pause = 1'b1;
    step();
    check("term_wrap_go", go_out, 1);
    check("term_wrap_busy", busy, 1);
    step();
    step();
    check("term_pause_count", count_in, 0);
    check("term_pause_measure", measure, 1);
    check("term_pause_en", en_out, 0);
    check("term_pause_busy", busy, 1);
    pause = 1'b0;
    wait_done("run2_done", MEAS_CYC + 100);
    check("run2_hits_left", exp_q.size(), 0);

    // ---- reset in the middle of a measure
    sb_load(1);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_count(3000, "reach_3000");
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_reset_busy", busy, 0);
    check("mid_reset_go", go_out, 1);
    check("mid_reset_measure", measure, 0);
    check("mid_reset_done", done, 0);
    step();
    check("mid_reset_count", count_in, 0);
    exp_q.delete();
    sb_load(1);
    start = 1'b1;
    step();
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      if (beat === 1'b1) got = 1'b1;
      else step();
    end
    check("restart_first_beat", got, 1);
    check("restart_first_idx", beat_idx, 0);
    check("restart_hits_left", exp_q.size(), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
